// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   bcd_state_t      : FSM state encoding (IDLE / SHIFT / DONE)
//   BCD_NUM_DIGITS   : number of BCD digits produced
//   BCD_MAX_VALUE    : largest value representable in four digits
//   BCD_NIB_W        : width of one BCD digit
//   BCD_SCR_W        : width of the BCD scratch register
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam int BCD_NUM_DIGITS = 4;
  localparam int BCD_MAX_VALUE  = 9999;
  localparam int BCD_NIB_W      = 4;
  localparam int BCD_SCR_W      = BCD_NUM_DIGITS * BCD_NIB_W;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
//   nib_i : BCD nibble before correction
//   nib_o : corrected nibble
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_NIB_W-1:0] nib_i,
  output logic [BCD_NIB_W-1:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: unsigned binary to four BCD digits.
// One shift per clock; the digit outputs are only written on completion so a
// downstream display multiplexer never sees a partial result. Inputs above
// 9999 saturate to 9999 and raise overflow alongside the digits.
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   start, bin      : conversion request and value, sampled only in IDLE
//   busy            : conversion in progress (registered, state != IDLE)
//   done            : one-cycle pulse, first IDLE cycle after completion
//   overflow        : last accepted bin exceeded 9999
//   digit1..digit4  : ones, tens, hundreds, thousands (plain BCD)
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [3:0]       digit4
);

  localparam int CNT_W = $clog2(BIN_W);
  // Compare in at least 14 bits so 9999 is representable; for narrower
  // inputs the zero-extended value can never exceed it.
  localparam int CMP_W = (BIN_W > 14) ? BIN_W : 14;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  bcd_state_t state_q, state_d;

  logic [BCD_SCR_W-1:0] scr_q, scr_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [BCD_NUM_DIGITS-1:0][BCD_NIB_W-1:0] dig_q, dig_d;

  // Saturation
  logic [CMP_W-1:0] bin_ext;
  logic             over_max;
  logic [BIN_W-1:0] bin_sat;

  assign bin_ext  = CMP_W'(bin);
  assign over_max = bin_ext > CMP_W'(BCD_MAX_VALUE);
  assign bin_sat  = over_max ? BIN_W'(BCD_MAX_VALUE) : bin;

  // Per-digit add-3 correction of the scratch register
  logic [BCD_SCR_W-1:0] scr_adj;

  for (genvar g = 0; g < BCD_NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (scr_q  [g*BCD_NIB_W +: BCD_NIB_W]),
      .nib_o (scr_adj[g*BCD_NIB_W +: BCD_NIB_W])
    );
  end

  // Combined shift: binary MSB moves into the scratch LSB.
  logic [BCD_SCR_W+BIN_W-1:0] cat_sh;
  assign cat_sh = {scr_adj, bin_q} << 1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    scr_d      = scr_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    dig_d      = dig_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d      = bin_sat;
          ovf_pend_d = over_max;
          scr_d      = '0;
          cnt_d      = '0;
        end
      end
      SHIFT: begin
        scr_d = cat_sh[BCD_SCR_W+BIN_W-1:BIN_W];
        bin_d = cat_sh[BIN_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
      end
      DONE: begin
        for (int i = 0; i < BCD_NUM_DIGITS; i++)
          dig_d[i] = scr_q[i*BCD_NIB_W +: BCD_NIB_W];
        ovf_d = ovf_pend_q;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scr_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      dig_q      <= '0;
    end else begin
      scr_q      <= scr_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      dig_q      <= dig_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign digit1   = dig_q[0];
  assign digit2   = dig_q[1];
  assign digit3   = dig_q[2];
  assign digit4   = dig_q[3];

endmodule
